bin2bcd_seq: RTL and testbench
==============================

# bin2bcd_seq

Sequential binary-to-BCD converter that feeds the seven-segment scan stage. It accepts an unsigned binary value over a valid/ready handshake and converts it with a shift-and-add-3 (double-dabble) loop, one bit per clock. It then presents DIGITS packed BCD nibbles, held stable, for the display stage to multiplex. Values the digits cannot represent saturate to all nines and raise an overflow flag.

## Interface
- BIN_W, 10, width of the binary input; must be ≥ 4.
- DIGITS, 3, number of BCD output digits; the maximum representable value is 10^DIGITS − 1.
- clk  input  1  single clock; all state changes on its rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- in_valid  input  1  in_bin holds a value to convert.
- in_ready  output  1  converter idle, able to accept.
- in_bin  input  BIN_W  unsigned binary value.
- out_valid  output  1  one-cycle pulse: out_bcd and out_ovf were just updated.
- out_bcd  output  4*DIGITS  packed BCD result:
  - [3:0] is the ones digit, [7:4] the tens digit, and so on upward.
  - The display stage maps its sel=0 to the most significant nibble.
- out_ovf  output  1  the last accepted value exceeded 10^DIGITS − 1.

## Operation
- States: IDLE and SHIFT. A bit counter ranges 0..BIN_W−1.
- IDLE:
  - in_ready = 1.
  - When in_valid & in_ready is sampled on an edge, the block:
    - loads the shift register with in_bin;
    - clears the BCD accumulator;
    - latches ovf_pend = (in_bin > 10^DIGITS − 1);
    - clears the counter and moves to SHIFT.
- SHIFT:
  - in_ready = 0.
  - On each edge, every accumulator nibble ≥ 5 has 3 added first. Then {accumulator, shift register} shifts left by one.
  - On the edge where counter = BIN_W−1, the block returns to IDLE and registers the result:
    - if ovf_pend = 0: out_bcd = the post-shift accumulator, out_ovf = 0;
    - if ovf_pend = 1: every nibble of out_bcd = 4'h9, out_ovf = 1.
  - The same edge sets out_valid = 1 for exactly one cycle.
- in_valid is ignored while in SHIFT. The source must hold in_bin until it sees in_ready, and the converter samples it only on acceptance.
- out_bcd and out_ovf hold their last result indefinitely. The display consumes them continuously and does not need to watch out_valid.
- Width rules:
  - The accumulator is 4*DIGITS bits.
  - Any accumulator carry beyond 4*DIGITS bits is discarded. This can occur only when ovf_pend = 1, in which case the saturated value replaces the result.
- Reset (at any time, including mid-SHIFT):
  - state = IDLE, in_ready = 1, out_valid = 0, out_bcd = 0, out_ovf = 0, counter = 0, accumulator = 0.
  - An aborted conversion produces no out_valid.

## Timing
- Acceptance edge k; out_valid is high in the cycle after edge k+BIN_W. Latency is BIN_W cycles.
- in_ready returns to 1 in the same cycle out_valid is high. A new value may be accepted on edge k+BIN_W+1.
- The back-to-back throughput is therefore one conversion per BIN_W+1 cycles.
- in_ready is a function of the registered state only; it has no combinational path from in_valid.
- out_bcd changes only on the edge that raises out_valid, or on reset.

## Structure
- Shared package bcd_pkg:
  - state enum (IDLE, SHIFT);
  - constant BCD_NINE = 4'h9;
  - constant ADD3_THRESHOLD = 4'd5;
  - constant function pow10(n) for computing the overflow limit.
- Sub-module bcd_add3_column: purely combinational, 4-bit in/out, adds 3 when the input is ≥ 5. Instantiate it DIGITS times via generate.

## Test plan
- **Basic conversion:** reset, then in_bin=107 with in_valid held.
  - Accept on the first edge after reset release.
  - out_valid pulses exactly 10 cycles later with out_bcd=12'h107, out_ovf=0.
- **Zero and maximum:** convert 0, then 999.
  - out_bcd = 12'h000, then 12'h999.
  - out_ovf = 0 for both.
- **Overflow:** in_bin=1000, then 1023.
  - Each gives out_bcd=12'h999 with out_ovf=1.
  - A following 5 gives 12'h005 with out_ovf=0.
- **Back-to-back:** in_valid held high with values 321 then 42.
  - in_ready is low during SHIFT.
  - The second acceptance occurs on the edge after the first out_valid.
  - Results are 12'h321 then 12'h042, spaced 11 cycles apart.
- **Reset mid-conversion:** assert rst_n=0 at cycle 5 of converting 555.
  - Outputs go immediately to 0/0/0 with in_ready=1.
  - No out_valid for 555; a subsequent 7 yields 12'h007.
- **Input change during SHIFT:** change in_bin from 200 to 800 while in SHIFT.
  - The result is still 12'h200, and out_bcd holds that value until the next out_valid.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bcd_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam logic [3:0] BCD_NINE       = 4'h9;
    localparam logic [3:0] ADD3_THRESHOLD = 4'd5;

    function automatic longint pow10(input int n);
        longint r;
        r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

endpackage

// File: rtl/bcd_add3_column.sv
// One double-dabble column: pre-corrects a BCD nibble before the left shift.
module bcd_add3_column
    import bcd_pkg::*;
(
    input  logic [3:0] i_nib,
    output logic [3:0] o_nib
);

    assign o_nib = (i_nib >= ADD3_THRESHOLD) ? i_nib + 4'd3 : i_nib;

endmodule

// File: rtl/bin2bcd_seq.sv
// Bit-serial binary-to-BCD converter (shift-and-add-3), one input bit per clock,
// with saturation to all nines when the value exceeds the digit range.
module bin2bcd_seq
    import bcd_pkg::*;
#(
    parameter int BIN_W  = 10,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [BIN_W-1:0]      in_bin,
    output logic                  out_valid,
    output logic [4*DIGITS-1:0]   out_bcd,
    output logic                  out_ovf
);

    localparam int ACC_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(BIN_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);
    localparam logic [63:0] LIMIT = 64'(pow10(DIGITS) - 1);

    state_t             r_state, w_state_nxt;
    logic [BIN_W-1:0]   r_sr;
    logic [ACC_W-1:0]   r_acc;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_ovf_pend;
    logic [ACC_W-1:0]   r_out_bcd;
    logic               r_out_ovf;
    logic               r_out_valid;

    logic               w_accept, w_last, w_ovf_in, w_carry;
    logic [ACC_W-1:0]   w_adj, w_acc_shift;
    logic [BIN_W-1:0]   w_sr_shift;

    for (genvar g = 0; g < DIGITS; g++) begin : g_col
        bcd_add3_column u_col (
            .i_nib (r_acc[4*g +: 4]),
            .o_nib (w_adj[4*g +: 4])
        );
    end

    // The carry out of the top nibble only appears for out-of-range inputs.
    assign {w_carry, w_acc_shift} = {w_adj, r_sr[BIN_W-1]};
    assign w_sr_shift = {r_sr[BIN_W-2:0], 1'b0};
    assign w_ovf_in   = (64'(in_bin) > LIMIT);

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (r_cnt == CNT_LAST) begin
                    w_last      = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sr        <= '0;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_ovf_pend  <= 1'b0;
            r_out_bcd   <= '0;
            r_out_ovf   <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= w_last;
            if (w_accept) begin
                r_sr       <= in_bin;
                r_acc      <= '0;
                r_cnt      <= '0;
                r_ovf_pend <= w_ovf_in;
            end else if (r_state == SHIFT) begin
                r_sr  <= w_sr_shift;
                r_acc <= w_acc_shift;
                r_cnt <= w_last ? '0 : r_cnt + 1'b1;
                if (w_last) begin
                    r_out_ovf <= r_ovf_pend | w_carry;
                    r_out_bcd <= (r_ovf_pend | w_carry) ? {DIGITS{BCD_NINE}} : w_acc_shift;
                end
            end
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = r_out_valid;
    assign out_bcd   = r_out_bcd;
    assign out_ovf   = r_out_ovf;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed bench for bin2bcd_seq: latency, saturation, back-to-back, reset abort.
module tb_bin2bcd_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [9:0]  in_bin;
    logic        out_valid;
    logic [11:0] out_bcd;
    logic        out_ovf;

    int checks   = 0;
    int failures = 0;

    bin2bcd_seq #(.BIN_W(10), .DIGITS(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_bin    (in_bin),
        .out_valid (out_valid),
        .out_bcd   (out_bcd),
        .out_ovf   (out_ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called on a negedge while idle; returns edges from acceptance to out_valid.
    task automatic run(input logic [9:0] v, output int lat);
        in_bin   = v;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic conv(input string tag, input logic [9:0] v,
                        input logic [11:0] exp_bcd, input logic exp_ovf);
        int lat;
        run(v, lat);
        chk({tag, "_lat"}, lat, 10);
        chk({tag, "_bcd"}, out_bcd, exp_bcd);
        chk({tag, "_ovf"}, out_ovf, exp_ovf);
        chk({tag, "_rdy"}, in_ready, 1);
        @(negedge clk);
        chk({tag, "_pulse"}, out_valid, 0);
    endtask

    initial begin
        int t;
        int seen;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_bin   = '0;
        repeat (3) @(negedge clk);
        chk("rst_rdy", in_ready, 1);
        chk("rst_vld", out_valid, 0);
        chk("rst_bcd", out_bcd, 0);
        chk("rst_ovf", out_ovf, 0);

        // Release reset and accept on the very next edge.
        rst_n = 1'b1;
        conv("basic107", 10'd107, 12'h107, 1'b0);
        conv("zero",     10'd0,   12'h000, 1'b0);
        conv("max999",   10'd999, 12'h999, 1'b0);
        conv("ovf1000",  10'd1000, 12'h999, 1'b1);
        conv("ovf1023",  10'd1023, 12'h999, 1'b1);
        conv("five",     10'd5,   12'h005, 1'b0);

        // Back-to-back with in_valid held high.
        in_bin   = 10'd321;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("b2b_busy", in_ready, 0);
        t = 0;
        while (!out_valid && t < 40) begin
            @(negedge clk);
            t++;
        end
        chk("b2b_lat1", t, 10);
        chk("b2b_bcd1", out_bcd, 12'h321);
        chk("b2b_rdy1", in_ready, 1);
        in_bin = 10'd42;
        t = 0;
        seen = 0;
        do begin
            @(negedge clk);
            t++;
            if (t == 1) chk("b2b_busy2", in_ready, 0);
        end while (!out_valid && t < 40);
        in_valid = 1'b0;
        chk("b2b_space", t, 11);
        chk("b2b_bcd2", out_bcd, 12'h042);
        @(negedge clk);

        // Reset in the middle of converting 555.
        in_bin   = 10'd555;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_vld", out_valid, 0);
        chk("mid_rst_bcd", out_bcd, 0);
        chk("mid_rst_ovf", out_ovf, 0);
        chk("mid_rst_rdy", in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (15) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("abort_no_vld", seen, 0);
        conv("after_rst7", 10'd7, 12'h007, 1'b0);

        // in_bin changes during SHIFT must not affect the result.
        in_bin   = 10'd200;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_bin   = 10'd800;
        t = 0;
        while (!out_valid && t < 40) begin
            @(negedge clk);
            t++;
        end
        chk("chg_lat", t, 10);
        chk("chg_bcd", out_bcd, 12'h200);
        chk("chg_ovf", out_ovf, 0);
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (out_bcd !== 12'h200) seen++;
        end
        chk("chg_hold", seen, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
